// File: rtl/project_period_counter_ctrl.sv
// project_period_counter_ctrl: register front-end for a period counter.
// Shadowed period/compare/phase registers with conditional transfer, run/start/stop FSM.
`default_nettype none

module project_period_counter_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_addr,
    input  logic [15:0] i_wr_data,
    input  logic [15:0] i_counter_value,
    output logic        o_en,
    output logic        o_phase_en,
    output logic [1:0]  o_mode,
    output logic [1:0]  o_sync_sel,
    output logic        o_sync_en,
    output logic        o_phase_direction,
    output logic [15:0] o_period,
    output logic [15:0] o_compare_b,
    output logic [15:0] o_phase,
    output logic        o_pending,
    output logic        o_running
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] c_ADDR_PERIOD = 3'd1;
    localparam logic [2:0] c_ADDR_CMPB   = 3'd2;
    localparam logic [2:0] c_ADDR_PHASE  = 3'd3;
    localparam logic [2:0] c_ADDR_COMMIT = 3'd4;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_mode;
    logic [1:0]  r_sync_sel;
    logic        r_sync_en;
    logic        r_phase_dir;
    logic [1:0]  r_load_mode;

    logic [15:0] r_sh_period;
    logic [15:0] r_sh_cmpb;
    logic [15:0] r_sh_phase;
    logic [15:0] r_period;
    logic [15:0] r_cmpb;
    logic [15:0] r_phase;
    logic        r_pending;

    logic        r_en;
    logic        r_phase_en;
    logic        r_running;
    logic        w_en_nxt;
    logic        w_phase_en_nxt;
    logic        w_running_nxt;

    logic        w_wr_ctrl;
    logic        w_commit;
    logic        w_at_zero;
    logic        w_at_period;
    logic        w_transfer;

    assign w_wr_ctrl   = i_wr_en && (i_wr_addr == c_ADDR_CTRL);
    assign w_commit    = i_wr_en && (i_wr_addr == c_ADDR_COMMIT) && i_wr_data[0];
    assign w_at_zero   = (i_counter_value == 16'd0);
    assign w_at_period = (i_counter_value == r_period);

    // Outside RUN a pending commit lands on the next edge; in RUN it waits for the alignment point.
    always_comb begin
        w_transfer = 1'b0;
        if (r_pending) begin
            if (r_state == ST_RUN) begin
                case (r_load_mode)
                    2'b00:   w_transfer = 1'b1;
                    2'b01:   w_transfer = w_at_zero;
                    2'b10:   w_transfer = w_at_period;
                    default: w_transfer = w_at_zero || w_at_period;
                endcase
            end else begin
                w_transfer = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = 1'b0;
        w_phase_en_nxt = 1'b0;
        w_running_nxt  = 1'b0;
        case (r_state)
            ST_STOPPED: if (w_wr_ctrl && i_wr_data[0]) w_state_nxt = ST_START;
            ST_START:   w_state_nxt = (w_wr_ctrl && !i_wr_data[0]) ? ST_STOPPED : ST_RUN;
            ST_RUN:     if (w_wr_ctrl && !i_wr_data[0]) w_state_nxt = ST_STOPPED;
            default:    w_state_nxt = ST_STOPPED;
        endcase
        // Outputs are registered from the next state so they line up with r_state.
        w_en_nxt       = (w_state_nxt == ST_START) || (w_state_nxt == ST_RUN);
        w_phase_en_nxt = (w_state_nxt == ST_START);
        w_running_nxt  = (w_state_nxt == ST_RUN);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_STOPPED;
            r_en       <= 1'b0;
            r_phase_en <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_phase_en <= w_phase_en_nxt;
            r_running  <= w_running_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mode      <= 2'b00;
            r_sync_sel  <= 2'b00;
            r_sync_en   <= 1'b0;
            r_phase_dir <= 1'b0;
            r_load_mode <= 2'b00;
            r_sh_period <= 16'd0;
            r_sh_cmpb   <= 16'd0;
            r_sh_phase  <= 16'd0;
        end else if (i_wr_en) begin
            case (i_wr_addr)
                c_ADDR_CTRL: begin
                    r_mode      <= i_wr_data[2:1];
                    r_sync_sel  <= i_wr_data[4:3];
                    r_sync_en   <= i_wr_data[5];
                    r_phase_dir <= i_wr_data[6];
                    r_load_mode <= i_wr_data[8:7];
                end
                c_ADDR_PERIOD: r_sh_period <= i_wr_data;
                c_ADDR_CMPB:   r_sh_cmpb   <= i_wr_data;
                c_ADDR_PHASE:  r_sh_phase  <= i_wr_data;
                default: ;
            endcase
        end
    end

    // Actives take the pre-write shadow values; a commit in the transfer cycle re-arms pending.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_period  <= 16'd0;
            r_cmpb    <= 16'd0;
            r_phase   <= 16'd0;
            r_pending <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_period <= r_sh_period;
                r_cmpb   <= r_sh_cmpb;
                r_phase  <= r_sh_phase;
            end
            if (w_commit)
                r_pending <= 1'b1;
            else if (w_transfer)
                r_pending <= 1'b0;
        end
    end

    assign o_en              = r_en;
    assign o_phase_en        = r_phase_en;
    assign o_running         = r_running;
    assign o_mode            = r_mode;
    assign o_sync_sel        = r_sync_sel;
    assign o_sync_en         = r_sync_en;
    assign o_phase_direction = r_phase_dir;
    assign o_period          = r_period;
    assign o_compare_b       = r_cmpb;
    assign o_phase           = r_phase;
    assign o_pending         = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_project_period_counter_ctrl.sv
// tb_project_period_counter_ctrl: directed self-checking bench for project_period_counter_ctrl.
`default_nettype none

module tb_project_period_counter_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] cnt;
    logic        en, phase_en, sync_en, phase_dir, pending, running;
    logic [1:0]  mode, sync_sel;
    logic [15:0] period, cmpb, phase;

    int n_tests = 0;
    int n_fail  = 0;

    project_period_counter_ctrl dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_wr_en           (wr_en),
        .i_wr_addr         (wr_addr),
        .i_wr_data         (wr_data),
        .i_counter_value   (cnt),
        .o_en              (en),
        .o_phase_en        (phase_en),
        .o_mode            (mode),
        .o_sync_sel        (sync_sel),
        .o_sync_en         (sync_en),
        .o_phase_direction (phase_dir),
        .o_period          (period),
        .o_compare_b       (cmpb),
        .o_phase           (phase),
        .o_pending         (pending),
        .o_running         (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One register write; returns 1 time unit after the edge that captured it.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'd0; cnt = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({en, phase_en, pending, running} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0000", {en, phase_en, pending, running});
        end
        n_tests++;
        if ({mode, sync_sel, sync_en, phase_dir, period, cmpb, phase} !== 54'd0) begin
            n_fail++; $display("FAIL reset_regs got %h exp 0", {mode, sync_sel, sync_en, phase_dir, period, cmpb, phase});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ctrl_fields();
        wr(3'd0, 16'h007E);
        n_tests++;
        if ({mode, sync_sel, sync_en, phase_dir, en} !== 7'b1111110) begin
            n_fail++; $display("FAIL ctrl_fields got %b exp 1111110", {mode, sync_sel, sync_en, phase_dir, en});
        end
        wr(3'd5, 16'hFFFF);
        wr(3'd7, 16'hFFFF);
        n_tests++;
        if ({mode, sync_sel, sync_en, phase_dir, pending, period} !== {7'b1111110, 16'd0}) begin
            n_fail++; $display("FAIL ignored_addr got %h exp %h", {mode, sync_sel, sync_en, phase_dir, pending, period}, {7'b1111110, 16'd0});
        end
        wr(3'd0, 16'h0000);
    endtask

    task automatic test_stopped_commit();
        wr(3'd1, 16'd100);
        n_tests++;
        if (period !== 16'd0) begin
            n_fail++; $display("FAIL shadow_no_effect got %0d exp 0", period);
        end
        wr(3'd4, 16'h0000);
        n_tests++;
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL commit_bit0_zero got %b exp 0", pending);
        end
        wr(3'd4, 16'h0001);
        n_tests++;
        if (pending !== 1'b1 || period !== 16'd0) begin
            n_fail++; $display("FAIL commit_arm got pend=%b per=%0d exp pend=1 per=0", pending, period);
        end
        tick();
        n_tests++;
        if (period !== 16'd100 || pending !== 1'b0 || en !== 1'b0) begin
            n_fail++; $display("FAIL stopped_xfer got per=%0d pend=%b en=%b exp 100 0 0", period, pending, en);
        end
    endtask

    task automatic test_start();
        wr(3'd2, 16'd33);
        wr(3'd3, 16'd20);
        wr(3'd4, 16'h0001);
        tick();
        n_tests++;
        if (phase !== 16'd20 || cmpb !== 16'd33 || period !== 16'd100) begin
            n_fail++; $display("FAIL start_xfer got ph=%0d cb=%0d per=%0d exp 20 33 100", phase, cmpb, period);
        end
        wr(3'd0, 16'h0003);
        n_tests++;
        if ({en, phase_en, running, mode} !== 5'b11001) begin
            n_fail++; $display("FAIL start_cycle got %b exp 11001", {en, phase_en, running, mode});
        end
        tick();
        n_tests++;
        if ({en, phase_en, running} !== 3'b101) begin
            n_fail++; $display("FAIL run_entry got %b exp 101", {en, phase_en, running});
        end
        wr(3'd0, 16'h0003);
        n_tests++;
        if ({en, phase_en, running} !== 3'b101) begin
            n_fail++; $display("FAIL rerun_no_restart got %b exp 101", {en, phase_en, running});
        end
    endtask

    task automatic test_zero_aligned();
        cnt = 16'd37;
        wr(3'd0, 16'h0083);
        wr(3'd1, 16'd50);
        wr(3'd4, 16'h0001);
        tick();
        tick();
        n_tests++;
        if (period !== 16'd100 || pending !== 1'b1) begin
            n_fail++; $display("FAIL zero_wait got per=%0d pend=%b exp 100 1", period, pending);
        end
        cnt = 16'd0;
        tick();
        n_tests++;
        if (period !== 16'd50 || pending !== 1'b0) begin
            n_fail++; $display("FAIL zero_xfer got per=%0d pend=%b exp 50 0", period, pending);
        end
    endtask

    task automatic test_period_aligned();
        cnt = 16'd7;
        wr(3'd0, 16'h0003);
        wr(3'd1, 16'd100);
        wr(3'd4, 16'h0001);
        tick();
        n_tests++;
        if (period !== 16'd100 || pending !== 1'b0) begin
            n_fail++; $display("FAIL immediate_xfer got per=%0d pend=%b exp 100 0", period, pending);
        end
        cnt = 16'd0;
        wr(3'd0, 16'h0103);
        wr(3'd1, 16'd60);
        wr(3'd4, 16'h0001);
        tick();
        tick();
        n_tests++;
        if (period !== 16'd100 || pending !== 1'b1) begin
            n_fail++; $display("FAIL period_wait got per=%0d pend=%b exp 100 1", period, pending);
        end
        cnt = 16'd100;
        tick();
        n_tests++;
        if (period !== 16'd60 || pending !== 1'b0) begin
            n_fail++; $display("FAIL period_xfer got per=%0d pend=%b exp 60 0", period, pending);
        end
    endtask

    task automatic test_back_to_back();
        cnt = 16'd5;
        wr(3'd0, 16'h0083);
        wr(3'd1, 16'd80);
        wr(3'd4, 16'h0001);
        cnt = 16'd0;
        wr(3'd1, 16'd75);
        n_tests++;
        if (period !== 16'd80 || pending !== 1'b0) begin
            n_fail++; $display("FAIL collide_shadow got per=%0d pend=%b exp 80 0", period, pending);
        end
        cnt = 16'd5;
        wr(3'd4, 16'h0001);
        cnt = 16'd0;
        wr(3'd4, 16'h0001);
        n_tests++;
        if (period !== 16'd75 || pending !== 1'b1) begin
            n_fail++; $display("FAIL collide_commit got per=%0d pend=%b exp 75 1", period, pending);
        end
        tick();
        n_tests++;
        if (period !== 16'd75 || pending !== 1'b0) begin
            n_fail++; $display("FAIL rearm_xfer got per=%0d pend=%b exp 75 0", period, pending);
        end
    endtask

    task automatic test_stop();
        cnt = 16'd9;
        wr(3'd1, 16'd44);
        wr(3'd4, 16'h0001);
        wr(3'd0, 16'h0080);
        n_tests++;
        if ({en, phase_en, running, pending} !== 4'b0001 || period !== 16'd75 || mode !== 2'b00) begin
            n_fail++; $display("FAIL stop got flags=%b per=%0d mode=%b exp 0001 75 00", {en, phase_en, running, pending}, period, mode);
        end
    endtask

    task automatic test_reset_mid_start();
        wr(3'd0, 16'h0001);
        n_tests++;
        if ({en, phase_en} !== 2'b11) begin
            n_fail++; $display("FAIL restart got %b exp 11", {en, phase_en});
        end
        rst = 1'b1;
        #2;
        n_tests++;
        if ({en, phase_en, pending, running, period, phase} !== 36'd0) begin
            n_fail++; $display("FAIL async_reset got %h exp 0", {en, phase_en, pending, running, period, phase});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({en, phase_en, running} !== 3'b000) begin
                n_fail++; $display("FAIL post_reset_quiet cyc%0d got %b exp 000", i, {en, phase_en, running});
            end
        end
        wr(3'd0, 16'h0001);
        n_tests++;
        if ({en, phase_en} !== 2'b11) begin
            n_fail++; $display("FAIL start_after_reset got %b exp 11", {en, phase_en});
        end
    endtask

    initial begin
        test_reset();
        test_ctrl_fields();
        test_stopped_commit();
        test_start();
        test_zero_aligned();
        test_period_aligned();
        test_back_to_back();
        test_stop();
        test_reset_mid_start();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/project_period_counter_ctrl.md
PROJECT_PERIOD_COUNTER_CTRL -- requirements
Module: project_period_counter_ctrl

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock, rising edge; i_reset  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: i_wr_en  in  1  register write strobe, one write per asserted cycle.
REQ-003 SHALL have: i_wr_addr  in  3  register address.
REQ-004 SHALL have: i_wr_data  in  16  write data.
REQ-005 SHALL have: i_counter_value  in  16  current count of the controlled period counter.
REQ-006 SHALL have: o_en  out  1  counter count enable.
REQ-007 SHALL have: o_phase_en  out  1  one-cycle phase-load strobe.
REQ-008 SHALL have the following counter configuration outputs:
- o_mode  out  2
- o_sync_sel  out  2
- o_sync_en  out  1
- o_phase_direction  out  1
REQ-009 SHALL have active values: o_period, o_compare_b, o_phase  out  16 each.
REQ-010 SHALL have: o_pending  out  1  shadow update awaiting transfer.
REQ-011 SHALL have: o_running  out  1  FSM in RUN state.

Function
REQ-012 SHALL decode the address map:
- 0 CTRL: bit0 run, [2:1] mode, [4:3] sync_sel, bit5 sync_en, bit6 phase_direction, [8:7] load_mode.
- 1 PERIOD shadow.
- 2 COMPARE_B shadow.
- 3 PHASE shadow.
- 4 COMMIT: bit0=1 arms transfer.
- 5-7 ignored, no state change.
REQ-013 SHALL apply CTRL fields mode, sync_sel, sync_en, phase_direction and load_mode directly to outputs/internal registers on the cycle after the write.
REQ-014 SHALL write addresses 1-3 into shadow registers only; active outputs SHALL NOT change on a shadow write.
REQ-015 SHALL set the pending flag on a COMMIT write with bit0=1; a COMMIT write with bit0=0 SHALL be ignored.
REQ-016 SHALL copy all three shadows to active registers in one cycle on a transfer event and clear pending in the same edge.
REQ-017 SHALL define the transfer event, while pending and in RUN, by load_mode:
- 00: immediate, next edge.
- 01: i_counter_value==0.
- 10: i_counter_value==o_period, compared against the active period.
- 11: either condition.
REQ-018 SHALL transfer on the edge following the COMMIT write while in STOPPED or START, regardless of load_mode.
REQ-019 SHALL evaluate the following simultaneous cases:
- Shadow write in the same cycle as a transfer: the pre-write shadow value is transferred and the new value stays in the shadow.
- New COMMIT in the same cycle as a transfer: pending remains set.
REQ-020 SHALL implement FSM states STOPPED, START, RUN.
REQ-021 SHALL perform STOPPED->START on a CTRL write with run=1; START SHALL last exactly one cycle with o_en=1 and o_phase_en=1.
REQ-022 SHALL go START->RUN unconditionally; in RUN o_en=1 and o_phase_en=0.
REQ-023 SHALL go RUN->STOPPED or START->STOPPED on a CTRL write with run=0; o_en=0 from the next cycle, and active registers and pending SHALL be held.
REQ-024 SHALL treat a CTRL write with run=1 while in START or RUN as a field update only, with no restart and no phase strobe.
REQ-025 SHALL register all outputs; o_running=1 exactly in RUN.
REQ-026 SHALL use 16-bit unsigned equality compares only, with no arithmetic wrap concerns.

Reset
REQ-027 SHALL on i_reset:
- Force STOPPED.
- o_en=0, o_phase_en=0, o_pending=0, o_running=0.
- All shadow and active registers=0; mode=00, sync_sel=00, sync_en=0, phase_direction=0, load_mode=00.
REQ-028 SHALL abort any START cycle or pending transfer on reset asserted mid-operation; no strobe SHALL be emitted after reset release until a new run write.

Verification
REQ-029 Stopped commit: write PERIOD=100, COMMIT=1 -> o_period=100 next cycle, o_pending 1-cycle pulse max, o_en=0.
REQ-030 Start: PHASE=20 committed, CTRL run=1 mode=01 -> next cycle o_en=1,o_phase_en=1 (one cycle), then o_running=1, o_phase_en=0.
REQ-031 Zero-aligned update: RUN, load_mode=01, PERIOD shadow=50, COMMIT; hold i_counter_value=37 -> o_period unchanged, o_pending=1; set i_counter_value=0 -> o_period=50, o_pending=0 next edge.
REQ-032 Period-aligned update: load_mode=10, active period=100, shadow=60 committed; i_counter_value=0 -> no transfer; i_counter_value=100 -> o_period=60.
REQ-033 Collision: transfer cycle coincides with PERIOD write 75 and a new COMMIT -> o_period=old shadow, shadow=75, o_pending stays 1.
REQ-034 Reset mid-START: assert i_reset during START cycle -> all outputs 0, no further o_phase_en until next run=1 write.
